// File: rtl/miner_target_checker.sv
// Share-target checker behind the double-SHA256 nonce pipeline: compares each digest
// against the expanded nBits target, queues winning nonces and keeps hash/hit statistics.
module miner_target_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tgt_load,
  input  logic [31:0]      tgt_bits,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0][31:0] in_digest,
  input  logic [31:0]      in_nonce,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [31:0]      hit_nonce,
  output logic [7:0][31:0] hit_digest,
  output logic [CNT_W-1:0] hash_count,
  output logic [CNT_W-1:0] hit_count,
  output logic [15:0]      drop_count,
  output logic [8:0]       best_zeros
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high
  // (and clear is low); valid never waits on ready, ready never depends on valid.
  logic accept, push, pop;

  logic [255:0] target_q, target_d, mant;
  logic [10:0]  sh_up, sh_dn;
  logic [255:0] v_in;
  logic [8:0]   lz_s1;

  logic             s1_valid_q, s2_valid_q, s2_hit_q;
  logic [255:0]     s1_v_q;
  logic [7:0][31:0] s1_digest_q, s2_digest_q;
  logic [31:0]      s1_nonce_q, s2_nonce_q;
  logic [8:0]       s2_lz_q, best_q;
  logic [CNT_W-1:0] hash_q, hit_q;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, fill, free_slots, in_flight;
  logic [31:0]      mem_nonce  [DEPTH];
  logic [7:0][31:0] mem_digest [DEPTH];

  // Compact nBits expansion; shifts of 256 or more fall off the top naturally.
  always_comb begin
    mant     = {233'd0, tgt_bits[22:0]};
    sh_up    = {tgt_bits[31:24], 3'b000} - 11'd24;
    sh_dn    = 11'd24 - {tgt_bits[31:24], 3'b000};
    target_d = target_q;
    if (tgt_load) begin
      target_d = '0;
      if (!tgt_bits[23] && (tgt_bits[22:0] != 23'd0)) begin
        if (tgt_bits[31:24] >= 8'd3) target_d = mant << sh_up;
        else                         target_d = mant >> sh_dn;
      end
    end
  end

  always_comb begin
    v_in = '0;
    for (int w = 0; w < 8; w++)
      v_in[32*w +: 32] = {in_digest[w][7:0], in_digest[w][15:8],
                          in_digest[w][23:16], in_digest[w][31:24]};
  end

  always_comb begin
    lz_s1 = 9'd256;
    for (int i = 0; i < 256; i++)
      if (s1_v_q[i]) lz_s1 = 9'(255 - i);
  end

  // Every pipeline entry may become a hit, so it must already own a free FIFO slot.
  assign fill       = wr_ptr_q - rd_ptr_q;
  assign free_slots = PW'(DEPTH) - fill;
  assign in_flight  = PW'(s1_valid_q) + PW'(s2_valid_q);
  assign in_ready   = free_slots > in_flight;
  assign hit_valid  = (wr_ptr_q != rd_ptr_q);

  assign accept = in_valid & in_ready & ~clear;
  assign push   = s2_valid_q & s2_hit_q & ~clear;
  assign pop    = hit_valid & hit_ready & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_v_q      <= '0;
      s1_digest_q <= '0;
      s1_nonce_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_hit_q    <= 1'b0;
      s2_lz_q     <= '0;
      s2_digest_q <= '0;
      s2_nonce_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hash_q      <= '0;
      hit_q       <= '0;
      best_q      <= '0;
    end else begin
      target_q <= target_d;
      if (clear) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        hash_q     <= '0;
        hit_q      <= '0;
        best_q     <= '0;
      end else begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_v_q      <= v_in;
          s1_digest_q <= in_digest;
          s1_nonce_q  <= in_nonce;
        end
        s2_valid_q  <= s1_valid_q;
        s2_hit_q    <= (s1_v_q <= target_q);
        s2_lz_q     <= lz_s1;
        s2_digest_q <= s1_digest_q;
        s2_nonce_q  <= s1_nonce_q;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (accept) hash_q <= hash_q + CNT_W'(1);
        if (push && (hit_q != '1)) hit_q <= hit_q + CNT_W'(1);
        if (s2_valid_q && (s2_lz_q > best_q)) best_q <= s2_lz_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce[wr_ptr_q[AW-1:0]]  <= s2_nonce_q;
      mem_digest[wr_ptr_q[AW-1:0]] <= s2_digest_q;
    end
  end

  assign hit_nonce  = mem_nonce[rd_ptr_q[AW-1:0]];
  assign hit_digest = mem_digest[rd_ptr_q[AW-1:0]];
  assign hash_count = hash_q;
  assign hit_count  = hit_q;
  assign drop_count = 16'd0;
  assign best_zeros = best_q;
endmodule

// File: tb/tb_miner_target_checker.sv
// Directed bench for miner_target_checker: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_miner_target_checker;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst, clear, tgt_load, in_valid, in_ready, hit_valid, hit_ready;
  logic [31:0] tgt_bits, in_nonce, hit_nonce;
  logic [7:0][31:0] in_digest, hit_digest;
  logic [31:0] hash_count, hit_count;
  logic [15:0] drop_count;
  logic [8:0]  best_zeros;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  miner_target_checker #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear), .tgt_load(tgt_load), .tgt_bits(tgt_bits),
    .in_valid(in_valid), .in_ready(in_ready), .in_digest(in_digest), .in_nonce(in_nonce),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_nonce(hit_nonce),
    .hit_digest(hit_digest), .hash_count(hash_count), .hit_count(hit_count),
    .drop_count(drop_count), .best_zeros(best_zeros)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [255:0] v;
    logic [255:0] d;
    logic [31:0]  n;
    logic [1:0]   age;
    logic         hit;
  } ent_t;

  ent_t m_pipe[$];
  ent_t m_fifo[$];
  ent_t m_nxt[$];
  ent_t m_e;
  logic [255:0] m_tgt = '0;
  logic [31:0]  m_hash = 0;
  logic [31:0]  m_hits = 0;
  int           m_best = 0;
  bit           m_acc, m_pop;

  function automatic logic [255:0] m_expand(input logic [31:0] b);
    logic [255:0] t;
    int e;
    e = int'(b[31:24]);
    t = {233'd0, b[22:0]};
    if (b[23] || (b[22:0] == 23'd0)) return '0;
    if (e >= 3) repeat (e - 3) t = t * 256;
    else        repeat (3 - e) t = t / 256;
    return t;
  endfunction

  function automatic logic [255:0] m_value(input logic [7:0][31:0] d);
    logic [255:0] v;
    v = '0;
    for (int w = 7; w >= 0; w--)
      for (int b = 0; b < 4; b++) v = v * 256 + 256'(d[w][8*b +: 8]);
    return v;
  endfunction

  function automatic int m_lz(input logic [255:0] v);
    logic [255:0] x;
    int n;
    x = v;
    n = 0;
    while (x != 0) begin
      x = x >> 1;
      n++;
    end
    return 256 - n;
  endfunction

  function automatic bit m_ready();
    return (DEPTH - m_fifo.size()) > m_pipe.size();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pipe.delete();
      m_fifo.delete();
      m_tgt = '0;
      m_hash = 0;
      m_hits = 0;
      m_best = 0;
    end else begin
      m_acc = in_valid && m_ready();
      m_pop = hit_ready && (m_fifo.size() > 0);
      if (clear) begin
        m_pipe.delete();
        m_fifo.delete();
        m_hash = 0;
        m_hits = 0;
        m_best = 0;
      end else begin
        if (m_pop) void'(m_fifo.pop_front());
        m_nxt.delete();
        foreach (m_pipe[i]) begin
          m_e = m_pipe[i];
          if (m_e.age == 2) begin
            if (m_e.hit) begin
              m_fifo.push_back(m_e);
              if (m_hits != 32'hffff_ffff) m_hits++;
            end
            if (m_lz(m_e.v) > m_best) m_best = m_lz(m_e.v);
          end else begin
            m_e.hit = (m_e.v <= m_tgt);
            m_e.age = 2;
            m_nxt.push_back(m_e);
          end
        end
        if (m_acc) begin
          m_e.v = m_value(in_digest);
          m_e.d = in_digest;
          m_e.n = in_nonce;
          m_e.age = 1;
          m_e.hit = 1'b0;
          m_nxt.push_back(m_e);
          m_hash++;
        end
        m_pipe = m_nxt;
      end
      if (tgt_load) m_tgt = m_expand(tgt_bits);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("in_ready", 256'(in_ready), 256'(m_ready()));
    chk("hit_valid", 256'(hit_valid), 256'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      chk("hit_nonce", 256'(hit_nonce), 256'(m_fifo[0].n));
      chk("hit_digest", hit_digest, m_fifo[0].d);
    end
    chk("hash_count", 256'(hash_count), 256'(m_hash));
    chk("hit_count", 256'(hit_count), 256'(m_hits));
    chk("best_zeros", 256'(best_zeros), 256'(m_best));
    chk("drop_count", 256'(drop_count), 256'd0);
  end

  logic [31:0] got_q[$];
  always @(negedge clk)
    if (!rst && !clear && hit_valid && hit_ready) got_q.push_back(hit_nonce);

  // ---------------- driver tasks ----------------
  int n_acc;
  bit last_ready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tgt(input logic [31:0] b);
    tgt_bits = b;
    tgt_load = 1'b1;
    tick();
    tgt_load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send(input logic [7:0][31:0] d, input logic [31:0] n);
    bit ok;
    ok = 1'b0;
    in_digest = d;
    in_nonce = n;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout nonce=%0h actual=in_ready_low required=accept", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after an accept edge: the hit must appear on the second edge after it.
  task automatic expect_at2(input string tag, input bit exp_hit, input logic [31:0] n);
    @(negedge clk);
    chk({tag, "_hv_c0"}, 256'(hit_valid), 256'd0);
    @(negedge clk);
    chk({tag, "_hv_c1"}, 256'(hit_valid), 256'd0);
    @(negedge clk);
    chk({tag, "_hv_c2"}, 256'(hit_valid), 256'(exp_hit));
    if (exp_hit) chk({tag, "_nonce"}, 256'(hit_nonce), 256'(n));
    tick();
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
  endtask

  function automatic logic [7:0][31:0] mk_stream(input int k);
    logic [31:0] u;
    u = 32'(k);
    return {32'h0, u * 32'h9e37_79b9, ~u, u ^ 32'h5a5a_5a5a, u << 3,
            32'hc0ff_ee00 | u, u * 32'd7, u};
  endfunction

  task automatic stream_cycles(input int cycles, input int total);
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      in_valid = (n_acc < total);
      in_nonce = BASE + 32'(n_acc);
      in_digest = mk_stream(n_acc);
      @(negedge clk);
      acc = in_valid && in_ready;
      last_ready = in_ready;
      tick();
      if (acc) n_acc++;
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0][31:0] low_word(input logic [31:0] w0);
    return {224'd0, w0};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0][31:0] d1, d2;
    rst = 1'b1; clear = 1'b0; tgt_load = 1'b0; tgt_bits = '0;
    in_valid = 1'b0; in_digest = '0; in_nonce = '0; hit_ready = 1'b0;
    d1 = {32'h0, 32'h0, 32'h78a4_67e0, 32'hfedd_4a02, 32'h2836_c9cd,
          32'h2da5_8a97, 32'h42bd_fa91, 32'h502a_9892};
    d2 = d1;
    d2[7] = 32'h0000_0001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_hit_valid", 256'(hit_valid), 256'd0);
    chk("rst_hash", 256'(hash_count), 256'd0);
    chk("rst_best", 256'(best_zeros), 256'd0);
    rst = 1'b0;
    tick();

    // Real block header result: V has 64 leading zeros and sits below the share target.
    load_tgt(32'h1901_5f53);
    send(d1, 32'h3308_7548);
    @(negedge clk);
    chk("t1_hv_c0", 256'(hit_valid), 256'd0);
    @(negedge clk);
    chk("t1_hv_c1", 256'(hit_valid), 256'd0);
    @(negedge clk);
    chk("t1_hv_c2", 256'(hit_valid), 256'd1);
    chk("t1_nonce", 256'(hit_nonce), 256'h3308_7548);
    chk("t1_digest", hit_digest, d1);
    chk("t1_hit_count", 256'(hit_count), 256'd1);
    chk("t1_best", 256'(best_zeros), 256'd64);
    tick();
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;

    // bswap(0x00000001) = 0x01000000 on top: seven leading zeros, far above the target.
    do_clear();
    send(d2, 32'h3308_7549);
    expect_at2("t2", 1'b0, 32'h0);
    @(negedge clk);
    chk("t2_hash", 256'(hash_count), 256'd1);
    chk("t2_hits", 256'(hit_count), 256'd0);
    chk("t2_best", 256'(best_zeros), 256'd7);
    tick();

    // Equality boundary, one-above, negative-flag target and the V=0 corner.
    do_clear();
    load_tgt(32'h0312_3456);
    send(low_word(32'h5634_1200), 32'h300);
    expect_at2("t3_eq", 1'b1, 32'h300);
    send(low_word(32'h5734_1200), 32'h301);
    expect_at2("t3_above", 1'b0, 32'h0);
    load_tgt(32'h0492_3456);
    send(low_word(32'h0100_0000), 32'h302);
    expect_at2("t3_neg_v1", 1'b0, 32'h0);
    send('0, 32'h303);
    expect_at2("t3_neg_v0", 1'b1, 32'h303);
    @(negedge clk);
    chk("t3_hits", 256'(hit_count), 256'd2);
    chk("t3_hash", 256'(hash_count), 256'd4);
    chk("t3_best", 256'(best_zeros), 256'd256);
    tick();

    // Backpressure with a stalled consumer, then streaming through pointer wrap.
    do_clear();
    load_tgt(32'h2100_ffff);
    got_q.delete();
    n_acc = 0;
    stream_cycles(30, 20);
    chk("t4_accepted", 256'(n_acc), 256'd8);
    chk("t4_ready_low", 256'(last_ready), 256'd0);
    hit_ready = 1'b1;
    stream_cycles(2, 20);
    chk("t4_ready_after_pop", 256'(last_ready), 256'd1);
    stream_cycles(100, 40);
    repeat (20) tick();
    chk("t5_accepted", 256'(n_acc), 256'd40);
    chk("t5_pop_count", 256'(got_q.size()), 256'd40);
    foreach (got_q[i]) chk("t5_order", 256'(got_q[i]), 256'(BASE + 32'(i)));
    hit_ready = 1'b0;

    // clear with two entries in flight, three queued and a concurrent accept attempt.
    do_clear();
    n_acc = 0;
    stream_cycles(5, 5);
    clear = 1'b1;
    in_valid = 1'b1;
    in_nonce = 32'hdead_0001;
    @(negedge clk);
    chk("t6_pre_hv", 256'(hit_valid), 256'd1);
    chk("t6_pre_hits", 256'(hit_count), 256'd3);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_hv", 256'(hit_valid), 256'd0);
    chk("t6_hash", 256'(hash_count), 256'd0);
    chk("t6_hits", 256'(hit_count), 256'd0);
    chk("t6_best", 256'(best_zeros), 256'd0);
    chk("t6_ready", 256'(in_ready), 256'd1);
    repeat (4) tick();
    @(negedge clk);
    chk("t6_no_late_hit", 256'(hit_count), 256'd0);
    tick();

    // Asynchronous reset mid-stream, then the target must be back at zero.
    n_acc = 0;
    stream_cycles(5, 5);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t6r_hv", 256'(hit_valid), 256'd0);
    chk("t6r_hash", 256'(hash_count), 256'd0);
    chk("t6r_hits", 256'(hit_count), 256'd0);
    chk("t6r_ready", 256'(in_ready), 256'd1);
    rst = 1'b0;
    tick();
    hit_ready = 1'b1;
    send(low_word(32'h0100_0000), 32'h400);
    repeat (4) tick();
    @(negedge clk);
    chk("t6r_tgt0_v1", 256'(hit_count), 256'd0);
    chk("t6r_hash1", 256'(hash_count), 256'd1);
    tick();
    send('0, 32'h401);
    repeat (4) tick();
    @(negedge clk);
    chk("t6r_tgt0_v0", 256'(hit_count), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
